// File: rtl/nes_controller_responder.sv
// Controller-side NES pad responder: emulates the 4021 shift register
// that a genuine pad presents to the console on latch/clock/data.
//
// Ports:
//   clk, rst_n   system clock, synchronous active-low reset
//   buttons_in   button byte (A,B,Sel,Start,Up,Down,Left,Right; 1=pressed)
//   buttons_we   one-cycle strobe capturing buttons_in into buttons_reg
//   nes_latch    asynchronous latch from the console side
//   nes_clk      asynchronous shift clock from the console side
//   nes_data     registered serial button data to the console side
//   frame_done   one-cycle pulse when the 8th shift edge is accepted
//   frame_count  latch falling edges seen, wraps 255->0
//   buttons_reg  current button byte readback
module nes_controller_responder #(
    parameter int   SYNC_STAGES = 2,
    parameter bit   ACTIVE_LOW  = 1'b1,
    parameter logic FILL_LEVEL  = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] buttons_in,
    input  logic       buttons_we,
    input  logic       nes_latch,
    input  logic       nes_clk,
    output logic       nes_data,
    output logic       frame_done,
    output logic [7:0] frame_count,
    output logic [7:0] buttons_reg
);

    logic [SYNC_STAGES-1:0] lat_sync_q;
    logic [SYNC_STAGES-1:0] clk_sync_q;
    logic                   lat_hist_q;
    logic                   clk_hist_q;

    logic [7:0] btn_q, btn_d;
    logic [7:0] shift_q, shift_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] fc_q, fc_d;
    logic       done_q, done_d;
    logic       data_q, data_d;

    logic lat_s, clk_s;
    logic lat_fall, clk_rise;

    assign lat_s    = lat_sync_q[SYNC_STAGES-1];
    assign clk_s    = clk_sync_q[SYNC_STAGES-1];
    assign lat_fall = ~lat_s & lat_hist_q;
    assign clk_rise = clk_s & ~clk_hist_q;

    // Mode is implied by lat_s and cnt_q: latched (LOAD), counting
    // (SHIFT, cnt<8) or exhausted (IDLE, cnt==8).
    always_comb begin
        btn_d   = buttons_we ? buttons_in : btn_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        fc_d    = fc_q;
        done_d  = 1'b0;
        if (lat_s) begin
            // Snapshot follows buttons_reg continuously while latched.
            shift_d = btn_q;
            cnt_d   = 4'd0;
        end else if (lat_fall) begin
            // A coincident clock edge is deliberately dropped here.
            cnt_d = 4'd0;
            fc_d  = fc_q + 8'd1;
        end else if (clk_rise && (cnt_q < 4'd8)) begin
            shift_d = {1'b0, shift_q[7:1]};
            cnt_d   = cnt_q + 4'd1;
            done_d  = (cnt_q == 4'd7);
        end
        // Output is derived from next state so it moves with the state.
        data_d = (cnt_d < 4'd8) ? (shift_d[0] ^ ACTIVE_LOW) : FILL_LEVEL;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lat_sync_q <= '0;
            clk_sync_q <= '0;
            lat_hist_q <= 1'b0;
            clk_hist_q <= 1'b0;
            btn_q      <= 8'd0;
            shift_q    <= 8'd0;
            cnt_q      <= 4'd8;
            fc_q       <= 8'd0;
            done_q     <= 1'b0;
            data_q     <= FILL_LEVEL;
        end else begin
            lat_sync_q <= {lat_sync_q[SYNC_STAGES-2:0], nes_latch};
            clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], nes_clk};
            lat_hist_q <= lat_s;
            clk_hist_q <= clk_s;
            btn_q      <= btn_d;
            shift_q    <= shift_d;
            cnt_q      <= cnt_d;
            fc_q       <= fc_d;
            done_q     <= done_d;
            data_q     <= data_d;
        end
    end

    assign nes_data    = data_q;
    assign frame_done  = done_q;
    assign frame_count = fc_q;
    assign buttons_reg = btn_q;

endmodule

// File: tb/tb_nes_controller_responder.sv
// Bench for nes_controller_responder: a console-side driver reads frames
// and compares them with a pad model derived from the protocol rules.
module tb_nes_controller_responder;

    logic       clk;
    logic       rst_n;
    logic [7:0] buttons_in;
    logic       buttons_we;
    logic       nes_latch;
    logic       nes_clk;
    logic       nes_data;
    logic       frame_done;
    logic [7:0] frame_count;
    logic [7:0] buttons_reg;

    int checks;
    int failures;
    int done_cnt;

    // Pad model state
    logic [7:0] m_btn;
    int         m_fc;

    nes_controller_responder dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .buttons_in  (buttons_in),
        .buttons_we  (buttons_we),
        .nes_latch   (nes_latch),
        .nes_clk     (nes_clk),
        .nes_data    (nes_data),
        .frame_done  (frame_done),
        .frame_count (frame_count),
        .buttons_reg (buttons_reg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk)
        if (frame_done === 1'b1) done_cnt++;

    // Genuine pad: pressed button reads back as 0 on the wire.
    function automatic logic [7:0] wire_byte(input logic [7:0] b);
        return ~b;
    endfunction

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic write_btn(input logic [7:0] v);
        @(negedge clk);
        buttons_in = v;
        buttons_we = 1'b1;
        @(negedge clk);
        buttons_we = 1'b0;
        m_btn = v;
    endtask

    task automatic latch_pulse(input int hi);
        @(negedge clk);
        nes_latch = 1'b1;
        wait_cyc(hi);
        nes_latch = 1'b0;
        m_fc = (m_fc + 1) % 256;
    endtask

    task automatic clk_pulse();
        nes_clk = 1'b1;
        wait_cyc(6);
        nes_clk = 1'b0;
        wait_cyc(6);
    endtask

    // Console-side read of one full frame (8 clock pulses).
    task automatic read_frame(output logic [7:0] bits, output int dn);
        int d0;
        d0 = done_cnt;
        latch_pulse(12);
        wait_cyc(6);
        bits[0] = nes_data;
        for (int i = 1; i < 8; i++) begin
            nes_clk = 1'b1;
            wait_cyc(6);
            bits[i] = nes_data;
            nes_clk = 1'b0;
            wait_cyc(6);
        end
        clk_pulse();
        dn = done_cnt - d0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        wait_cyc(3);
        checks++;
        if (nes_data !== 1'b0) begin
            failures++;
            $display("FAIL reset_data got=%b exp=0", nes_data);
        end
        rst_n = 1'b1;
        wait_cyc(2);
        checks++;
        if (frame_count !== 8'd0 || buttons_reg !== 8'd0 || frame_done !== 1'b0) begin
            failures++;
            $display("FAIL reset_regs got fc=%0d br=%h fd=%b exp 0/00/0",
                     frame_count, buttons_reg, frame_done);
        end
        m_btn = 8'd0;
        m_fc  = 0;
    endtask

    task automatic test_single_a();
        logic [7:0] got;
        int dn;
        write_btn(8'h01);
        read_frame(got, dn);
        checks++;
        if (got !== wire_byte(8'h01)) begin
            failures++;
            $display("FAIL a_bits got=%b exp=%b", got, wire_byte(8'h01));
        end
        checks++;
        if (dn !== 1) begin
            failures++;
            $display("FAIL a_done got=%0d exp=1", dn);
        end
        checks++;
        if (frame_count !== 8'(m_fc)) begin
            failures++;
            $display("FAIL a_count got=%0d exp=%0d", frame_count, m_fc);
        end
        checks++;
        if (nes_data !== 1'b0) begin
            failures++;
            $display("FAIL a_fill got=%b exp=0", nes_data);
        end
    endtask

    task automatic test_fill_extra();
        logic [7:0] got;
        int dn;
        int d0;
        write_btn(8'hA5);
        read_frame(got, dn);
        checks++;
        if (got !== 8'h5A) begin
            failures++;
            $display("FAIL a5_bits got=%b exp=%b", got, 8'h5A);
        end
        d0 = done_cnt;
        repeat (3) clk_pulse();
        checks++;
        if (nes_data !== 1'b0 || done_cnt != d0) begin
            failures++;
            $display("FAIL extra_clk got data=%b done=%0d exp 0/0",
                     nes_data, done_cnt - d0);
        end
    endtask

    task automatic test_random_frames();
        logic [7:0] r;
        logic [7:0] got;
        int dn;
        for (int k = 0; k < 10; k++) begin
            r = 8'($urandom);
            write_btn(r);
            checks++;
            if (buttons_reg !== m_btn) begin
                failures++;
                $display("FAIL rnd_reg got=%h exp=%h", buttons_reg, m_btn);
            end
            read_frame(got, dn);
            checks++;
            if (got !== wire_byte(r) || dn !== 1
                || frame_count !== 8'(m_fc)) begin
                failures++;
                $display("FAIL rnd_frame got=%b/%0d/%0d exp=%b/1/%0d",
                         got, dn, frame_count, wire_byte(r), m_fc);
            end
        end
    endtask

    task automatic test_write_mid_shift();
        logic [7:0] got;
        int dn;
        write_btn(8'h00);
        latch_pulse(12);
        wait_cyc(6);
        got[0] = nes_data;
        for (int i = 1; i < 8; i++) begin
            if (i == 3) write_btn(8'hFF);
            nes_clk = 1'b1;
            wait_cyc(6);
            got[i] = nes_data;
            nes_clk = 1'b0;
            wait_cyc(6);
        end
        clk_pulse();
        checks++;
        if (got !== 8'hFF) begin
            failures++;
            $display("FAIL mid_cur got=%b exp=11111111", got);
        end
        read_frame(got, dn);
        checks++;
        if (got !== wire_byte(8'hFF)) begin
            failures++;
            $display("FAIL mid_next got=%b exp=%b", got, wire_byte(8'hFF));
        end
    endtask

    task automatic test_clk_during_latch();
        logic [7:0] got;
        write_btn(8'h96);
        @(negedge clk);
        nes_latch = 1'b1;
        wait_cyc(4);
        repeat (3) clk_pulse();
        nes_latch = 1'b0;
        m_fc = (m_fc + 1) % 256;
        wait_cyc(6);
        got[0] = nes_data;
        for (int i = 1; i < 8; i++) begin
            nes_clk = 1'b1;
            wait_cyc(6);
            got[i] = nes_data;
            nes_clk = 1'b0;
            wait_cyc(6);
        end
        clk_pulse();
        checks++;
        if (got !== wire_byte(8'h96)) begin
            failures++;
            $display("FAIL latch_clk got=%b exp=%b", got, wire_byte(8'h96));
        end
    endtask

    task automatic test_simultaneous();
        logic [7:0] got;
        write_btn(8'h3B);
        @(negedge clk);
        nes_latch = 1'b1;
        wait_cyc(12);
        nes_latch = 1'b0;
        nes_clk   = 1'b1;
        m_fc = (m_fc + 1) % 256;
        wait_cyc(6);
        got[0] = nes_data;
        nes_clk = 1'b0;
        wait_cyc(6);
        for (int i = 1; i < 8; i++) begin
            nes_clk = 1'b1;
            wait_cyc(6);
            got[i] = nes_data;
            nes_clk = 1'b0;
            wait_cyc(6);
        end
        clk_pulse();
        checks++;
        if (got !== wire_byte(8'h3B)) begin
            failures++;
            $display("FAIL simul got=%b exp=%b", got, wire_byte(8'h3B));
        end
    endtask

    task automatic test_latency();
        write_btn(8'h00);
        @(negedge clk);
        nes_latch = 1'b1;
        wait_cyc(2);
        checks++;
        if (nes_data !== 1'b0) begin
            failures++;
            $display("FAIL lat_early got=%b exp=0", nes_data);
        end
        wait_cyc(1);
        checks++;
        if (nes_data !== 1'b1) begin
            failures++;
            $display("FAIL lat_ontime got=%b exp=1", nes_data);
        end
        nes_latch = 1'b0;
        m_fc = (m_fc + 1) % 256;
        wait_cyc(6);
    endtask

    task automatic test_reset_mid();
        logic [7:0] got;
        int dn;
        write_btn(8'h0F);
        latch_pulse(12);
        wait_cyc(6);
        repeat (4) clk_pulse();
        rst_n = 1'b0;
        wait_cyc(2);
        rst_n = 1'b1;
        m_btn = 8'd0;
        m_fc  = 0;
        wait_cyc(1);
        checks++;
        if (nes_data !== 1'b0 || frame_count !== 8'd0
            || buttons_reg !== 8'd0) begin
            failures++;
            $display("FAIL rst_mid got d=%b fc=%0d br=%h exp 0/0/00",
                     nes_data, frame_count, buttons_reg);
        end
        read_frame(got, dn);
        checks++;
        if (got !== 8'hFF || dn !== 1) begin
            failures++;
            $display("FAIL rst_next got=%b/%0d exp=11111111/1", got, dn);
        end
    endtask

    task automatic test_count_wrap();
        int start;
        start = m_fc;
        for (int k = 0; k < 256; k++) begin
            latch_pulse(4);
            wait_cyc(4);
            if (m_fc == 0) begin
                checks++;
                if (frame_count !== 8'd0) begin
                    failures++;
                    $display("FAIL wrap_zero got=%0d exp=0", frame_count);
                end
            end
        end
        checks++;
        if (frame_count !== 8'(start)) begin
            failures++;
            $display("FAIL wrap_full got=%0d exp=%0d", frame_count, start);
        end
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        done_cnt   = 0;
        rst_n      = 1'b0;
        buttons_in = 8'd0;
        buttons_we = 1'b0;
        nes_latch  = 1'b0;
        nes_clk    = 1'b0;
        m_btn      = 8'd0;
        m_fc       = 0;
        test_reset();
        test_single_a();
        test_fill_extra();
        test_random_frames();
        test_write_mid_shift();
        test_clk_during_latch();
        test_simultaneous();
        test_latency();
        test_reset_mid();
        test_count_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
